calc_engine: RTL and testbench

CALC_ENGINE -- requirements
Module: calc_engine

---
 rtl/calc_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_calc_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_engine.sv
`default_nettype none
// ============================================================================
// Module   : calc_engine
// Purpose  : Button-driven decimal operand entry plus a small signed ALU
//            (add / subtract / multiply / restoring divide) with saturation
//            to +/-(10^NUM_DIGITS - 1).
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            UP/DOWN/LEFT/RIGHT/SELECT - single-cycle button pulses
//            mode              - entry enabled when mode == 1
//            sw                - sign of the entered operand (1 = negative)
//            operation         - 0 add, 1 sub, 2 mul, 3 div (sampled on SELECT)
//            current_value     - left operand (sampled on SELECT)
//            num_converted     - signed value of the digits being entered
//            new_value         - result of the last completed operation
//            result_valid      - one-cycle pulse when new_value/overflow update
//            busy              - operation in flight
//            overflow          - error flag of the last completed operation
//            digit             - index of the digit being edited (0 = LSB)
// Revision : 1.0 - initial release
// ============================================================================
module calc_engine #(
  parameter int NUM_DIGITS = 4,
  parameter int WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    UP,
  input  logic                    DOWN,
  input  logic                    LEFT,
  input  logic                    RIGHT,
  input  logic                    SELECT,
  input  logic [1:0]              mode,
  input  logic                    sw,
  input  logic [1:0]              operation,
  input  logic signed [WIDTH-1:0] current_value,
  output logic signed [WIDTH-1:0] num_converted,
  output logic signed [WIDTH-1:0] new_value,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    overflow,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit
);

  localparam int c_DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_W2 = 2 * WIDTH;
  localparam int c_CW = $clog2(WIDTH + 1);
  localparam logic signed [c_W2-1:0] c_MAX = c_W2'(10**NUM_DIGITS - 1);
  localparam logic signed [c_W2-1:0] c_MIN = -c_MAX;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t                   r_state;
  logic [3:0]               r_digits [NUM_DIGITS];
  logic [c_DW-1:0]          r_digit;
  logic signed [WIDTH-1:0]  r_a;
  logic signed [WIDTH-1:0]  r_b;
  logic [1:0]               r_op;
  logic                     r_neg;   // quotient sign
  logic [WIDTH-1:0]         r_dq;    // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]         r_dvs;   // |divisor|
  logic [WIDTH-1:0]         r_rem;   // partial remainder
  logic [c_CW-1:0]          r_cnt;
  logic signed [WIDTH-1:0]  r_nv;
  logic                     r_ovf;
  logic                     r_valid;
  logic                     r_busy;

  // Decimal digits to binary magnitude (Horner form, MSB digit first).
  logic [WIDTH-1:0] w_mag;
  always_comb begin
    w_mag = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_mag = w_mag * WIDTH'(10) + WIDTH'(r_digits[i]);
    end
  end
  assign num_converted = sw ? -$signed(w_mag) : $signed(w_mag);

  // Magnitudes for the divider; the most negative value maps correctly to
  // its unsigned magnitude.
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  assign w_abs_a = current_value[WIDTH-1] ? WIDTH'(-current_value) : WIDTH'(current_value);
  assign w_abs_b = num_converted[WIDTH-1] ? WIDTH'(-num_converted) : WIDTH'(num_converted);

  // One restoring-division step. The true difference is always below
  // 2^WIDTH, so a WIDTH-bit subtraction is exact.
  logic [WIDTH:0]   w_rem_sh;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  assign w_rem_sh   = {r_rem, r_dq[WIDTH-1]};
  assign w_fits     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_next = w_fits ? (w_rem_sh[WIDTH-1:0] - r_dvs) : w_rem_sh[WIDTH-1:0];

  // Double-width arithmetic so no intermediate result can wrap.
  logic signed [c_W2-1:0] w_a2;
  logic signed [c_W2-1:0] w_b2;
  logic signed [c_W2-1:0] w_arith;
  logic        [c_W2-1:0] w_qext;
  logic signed [c_W2-1:0] w_quot;
  logic signed [c_W2-1:0] w_sat_in;
  logic signed [WIDTH-1:0] w_sat_val;
  logic                    w_sat_ovf;

  assign w_a2   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_b2   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_qext = {{WIDTH{1'b0}}, r_dq};
  assign w_quot = r_neg ? -$signed(w_qext) : $signed(w_qext);

  always_comb begin
    w_arith = '0;
    case (r_op)
      2'd0:    w_arith = w_a2 + w_b2;
      2'd1:    w_arith = w_a2 - w_b2;
      2'd2:    w_arith = w_a2 * w_b2;
      default: w_arith = '0;
    endcase
  end

  assign w_sat_in = (r_state == S_EXEC) ? w_arith : w_quot;

  always_comb begin
    w_sat_val = w_sat_in[WIDTH-1:0];
    w_sat_ovf = 1'b0;
    if (w_sat_in > c_MAX) begin
      w_sat_val = c_MAX[WIDTH-1:0];
      w_sat_ovf = 1'b1;
    end else if (w_sat_in < c_MIN) begin
      w_sat_val = c_MIN[WIDTH-1:0];
      w_sat_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      for (int i = 0; i < NUM_DIGITS; i++) r_digits[i] <= '0;
      r_digit <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_dq    <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_nv    <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mode == 2'd1) begin
            if (UP) begin
              r_digits[r_digit] <= (r_digits[r_digit] == 4'd9) ? 4'd0 : r_digits[r_digit] + 4'd1;
            end else if (DOWN) begin
              r_digits[r_digit] <= (r_digits[r_digit] == 4'd0) ? 4'd9 : r_digits[r_digit] - 4'd1;
            end else if (LEFT) begin
              r_digit <= (r_digit == c_DW'(NUM_DIGITS - 1)) ? '0 : r_digit + c_DW'(1);
            end else if (RIGHT) begin
              r_digit <= (r_digit == '0) ? c_DW'(NUM_DIGITS - 1) : r_digit - c_DW'(1);
            end else if (SELECT) begin
              r_a     <= current_value;
              r_b     <= num_converted;
              r_op    <= operation;
              r_neg   <= current_value[WIDTH-1] ^ num_converted[WIDTH-1];
              r_dq    <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_rem   <= '0;
              r_cnt   <= '0;
              for (int i = 0; i < NUM_DIGITS; i++) r_digits[i] <= '0;
              r_digit <= '0;
              r_busy  <= 1'b1;
              r_state <= (operation == 2'd3) ? S_DIV : S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_nv    <= w_sat_val;
          r_ovf   <= w_sat_ovf;
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DIV: begin
          if (r_b == '0) begin
            // Divide by zero: flag it, keep the previous result.
            r_ovf   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else if (r_cnt != c_CW'(WIDTH)) begin
            r_rem <= w_rem_next;
            r_dq  <= {r_dq[WIDTH-2:0], w_fits};
            r_cnt <= r_cnt + c_CW'(1);
          end else begin
            // Extra cycle after the last quotient bit applies sign and
            // saturation, giving WIDTH+2 cycles from SELECT to result.
            r_nv    <= w_sat_val;
            r_ovf   <= w_sat_ovf;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign new_value    = r_nv;
  assign overflow     = r_ovf;
  assign result_valid = r_valid;
  assign busy         = r_busy;
  assign digit        = r_digit;

endmodule
`default_nettype wire

// File: tb/tb_calc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_engine
// Purpose  : Self-checking bench for calc_engine. Stimulus updates an
//            arithmetic reference model and pushes expected results into a
//            scoreboard queue; a monitor pops and compares on result_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_engine;
  localparam int ND   = 4;
  localparam int W    = 16;
  localparam int MAXV = 9999;

  logic clk = 1'b0;
  logic rst;
  logic UP, DOWN, LEFT, RIGHT, SELECT, sw;
  logic [1:0] mode, operation;
  logic signed [W-1:0] current_value;
  wire signed [W-1:0] num_converted, new_value;
  wire result_valid, busy, overflow;
  wire [1:0] digit;

  calc_engine #(.NUM_DIGITS(ND), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .UP(UP), .DOWN(DOWN), .LEFT(LEFT), .RIGHT(RIGHT),
    .SELECT(SELECT), .mode(mode), .sw(sw), .operation(operation),
    .current_value(current_value), .num_converted(num_converted),
    .new_value(new_value), .result_valid(result_valid), .busy(busy),
    .overflow(overflow), .digit(digit)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    bit     ovf;
    int     lat;
    int     sel_cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   m_e;
  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  int     busy_cnt = 0;
  int     md[ND];
  int     mdig     = 0;
  longint m_nv     = 0;
  bit     model_idle = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint mval();
    longint v = 0;
    for (int i = ND - 1; i >= 0; i--) v = v * 10 + md[i];
    return sw ? -v : v;
  endfunction

  function automatic void push_exp(longint a, longint b, int op);
    exp_t   e;
    longint r;
    bit     o = 1'b0;
    e.lat = 2;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      default: begin
        if (b == 0) r = 0;
        else begin
          r = a / b;
          e.lat = W + 2;
        end
      end
    endcase
    if (op == 3 && b == 0) begin
      o = 1'b1;
      r = m_nv;
    end else if (r > MAXV) begin
      r = MAXV; o = 1'b1;
    end else if (r < -MAXV) begin
      r = -MAXV; o = 1'b1;
    end
    m_nv      = r;
    e.val     = r;
    e.ovf     = o;
    e.sel_cyc = cyc;
    sb.push_back(e);
  endfunction

  // One clock with the given button pulses; the model follows the DUT rules.
  task automatic step(bit u, bit d, bit l, bit r, bit s);
    UP = u; DOWN = d; LEFT = l; RIGHT = r; SELECT = s;
    @(posedge clk); #1;
    UP = 0; DOWN = 0; LEFT = 0; RIGHT = 0; SELECT = 0;
    if (model_idle && mode == 2'd1) begin
      if (u)      md[mdig] = (md[mdig] + 1) % 10;
      else if (d) md[mdig] = (md[mdig] + 9) % 10;
      else if (l) mdig = (mdig + 1) % ND;
      else if (r) mdig = (mdig + ND - 1) % ND;
      else if (s) begin
        push_exp(longint'(current_value), mval(), int'(operation));
        for (int i = 0; i < ND; i++) md[i] = 0;
        mdig = 0;
        model_idle = 1'b0;
      end
    end
    if (model_idle) begin
      chk("num_converted", longint'(num_converted), mval());
      chk("digit", longint'(digit), longint'(mdig));
    end
  endtask

  task automatic enter(int v);
    for (int i = 0; i < ND; i++) begin
      repeat ((v / (10 ** i)) % 10) step(1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
    end
  endtask

  // Run until the scoreboard drains, optionally disturbing inputs meanwhile.
  task automatic wait_result(bit disturb);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      if (disturb) begin
        mode          = 2'($urandom);
        sw            = 1'($urandom);
        operation     = 2'($urandom);
        current_value = 16'($urandom);
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        step(0, 0, 0, 0, 0);
      end
      n++;
    end
    if (sb.size() != 0) begin
      chk("result_timeout", 0, 1);
      sb.delete();
    end
    model_idle = 1'b1;
    mode = 2'd1;
    chk("idle_busy", longint'(busy), 0);
    chk("idle_num_converted", longint'(num_converted), mval());
    chk("idle_digit", longint'(digit), 0);
  endtask

  task automatic rand_op();
    int         n;
    logic [3:0] m;
    sw = 1'($urandom);
    n  = $urandom_range(12, 0);
    for (int k = 0; k < n; k++) begin
      m    = 4'($urandom);
      mode = ($urandom_range(7, 0) == 0) ? 2'($urandom) : 2'd1;
      step(m[3], m[2], m[1], m[0], 0);
    end
    mode = 2'd1;
    if ($urandom_range(1, 0) == 1) current_value = 16'($urandom);
    else current_value = 16'($urandom_range(24000, 0) - 12000);
    operation = 2'($urandom);
    step(0, 0, 0, 0, 1);
    wait_result(1'($urandom));
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_new_value"}, longint'(new_value), 0);
    chk({tag, "_overflow"}, longint'(overflow), 0);
    chk({tag, "_result_valid"}, longint'(result_valid), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_digit"}, longint'(digit), 0);
    chk({tag, "_num_converted"}, longint'(num_converted), 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (result_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result_valid", 1, 0);
        end else begin
          m_e = sb.pop_front();
          chk("new_value", longint'(new_value), m_e.val);
          chk("overflow", longint'(overflow), longint'(m_e.ovf));
          chk("latency", longint'(cyc - m_e.sel_cyc), longint'(m_e.lat - 1));
          chk("busy_cycles", longint'(busy_cnt), longint'(m_e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < ND; i++) md[i] = 0;
    rst = 1'b1;
    UP = 0; DOWN = 0; LEFT = 0; RIGHT = 0; SELECT = 0;
    mode = 2'd1; sw = 1'b0; operation = 2'd0; current_value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Digit entry, wraps and button priority.
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0);
    chk("entry_23", longint'(num_converted), 23);
    chk("entry_23_digit", longint'(digit), 1);
    repeat (3) step(0, 1, 0, 0, 0);
    chk("down_wrap", longint'(num_converted), 93);
    step(1, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 1, 0);
    chk("right_wrap_digit", longint'(digit), 3);
    step(0, 0, 1, 0, 0);
    chk("left_wrap_digit", longint'(digit), 0);
    current_value = 16'sd0; operation = 2'd0;
    step(0, 0, 0, 0, 1);
    wait_result(0);

    // Saturating add.
    current_value = 16'sd9990; sw = 0; enter(25); operation = 2'd0;
    step(0, 0, 0, 0, 1);
    wait_result(0);
    chk("add_sat_value", longint'(new_value), 9999);
    chk("add_sat_overflow", longint'(overflow), 1);

    // Negative operand multiply.
    current_value = -16'sd100; sw = 1; enter(7); operation = 2'd2;
    step(0, 0, 0, 0, 1);
    wait_result(0);
    chk("mul_value", longint'(new_value), 700);

    // Divide, then divide by zero keeps the value.
    current_value = -16'sd9999; sw = 0; enter(4); operation = 2'd3;
    step(0, 0, 0, 0, 1);
    wait_result(0);
    chk("div_value", longint'(new_value), -2499);
    current_value = 16'sd5; operation = 2'd3;
    step(0, 0, 0, 0, 1);
    wait_result(0);
    chk("div0_value", longint'(new_value), -2499);
    chk("div0_overflow", longint'(overflow), 1);

    // Buttons and input changes while busy are ignored.
    current_value = 16'sd50; sw = 0; enter(3); operation = 2'd1;
    step(0, 0, 0, 0, 1);
    wait_result(1);

    // Reset in the middle of a divide.
    current_value = 16'sd1234; sw = 0; enter(7); operation = 2'd3;
    step(0, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("mid_div_reset");
    sb.delete();
    for (int i = 0; i < ND; i++) md[i] = 0;
    mdig = 0; m_nv = 0; model_idle = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (W + 4) step(0, 0, 0, 0, 0);

    // Randomized operations.
    for (int it = 0; it < 40; it++) rand_op();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
